pcm_frame_fifo: RTL and testbench
=================================

PCM_FRAME_FIFO -- requirements
Module: pcm_frame_fifo

Interface
REQ-001 SHALL have parameter AUDIO_DW, default 32, output sample width (legal range 16..32).
REQ-002 SHALL have parameter DEPTH_LOG2, default 8, FIFO depth of 2^DEPTH_LOG2 stereo frames.
REQ-003 SHALL have parameter IRQ_THRESH, default 128, frame level below which irq asserts.
REQ-004 SHALL have port clk, input, 1, system clock; reset is synchronous to clk.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port wr_strobe, input, 1, one-cycle write of wr_data from the ISA side.
REQ-007 SHALL have port wr_data, input, 16, signed two's-complement PCM sample.
REQ-008 SHALL have port flush, input, 1, one-cycle FIFO clear.
REQ-009 SHALL have port sample_tick, input, 1, one-cycle pulse at the sample rate, from the I2S clock domain logic.
REQ-010 SHALL have port irq_en, input, 1, gates irq.
REQ-011 SHALL have port ovf_clr, input, 1, and port udr_clr, input, 1, which clear the sticky flags.
REQ-012 SHALL have port left_chan, output, AUDIO_DW, and port right_chan, output, AUDIO_DW, which feed the I2S serializer.
REQ-013 SHALL have port level, output, DEPTH_LOG2+1, count of committed frames.
REQ-014 SHALL have output ports full, 1; overflow, 1 (sticky); underrun, 1 (sticky); irq, 1.

Function
REQ-015 SHALL treat writes as interleaved pairs: the first wr_strobe holds the left sample in a staging register; the second commits the {left, right} frame to the FIFO; a 1-bit phase register tracks the pair.
REQ-016 SHALL drop a committing write when full=1, set overflow, and return the phase to left.
REQ-017 SHALL assert full combinationally when level == 2^DEPTH_LOG2; read/write pointers SHALL wrap modulo depth.
REQ-018 SHALL pop one frame when sample_tick=1 and level>0, and present it on left_chan/right_chan in the cycle after the tick (latency 1); outputs SHALL hold until the next tick.
REQ-019 SHALL, when sample_tick=1 and level==0, drive both outputs to 0 in the next cycle and set underrun.
REQ-020 SHALL evaluate emptiness before the same-cycle commit: a commit and a tick together with level==0 SHALL store the frame, raise underrun, and leave level at 1.
REQ-021 SHALL leave level unchanged when a commit and a pop occur in the same cycle with 0<level<full.
REQ-022 SHALL left-justify the output: bits [AUDIO_DW-1:AUDIO_DW-16] = sample; lower bits = 0.
REQ-023 SHALL compute irq = irq_en & (level < IRQ_THRESH), registered (1-cycle delay).
REQ-024 SHALL, on flush, zero the pointers, level, phase and both outputs in the next cycle; overflow/underrun SHALL be unaffected; flush SHALL override a same-cycle write or tick.
REQ-025 SHALL clear a sticky flag on its clr input; a same-cycle set SHALL win over clear.

Reset
REQ-026 SHALL reset left_chan=0, right_chan=0, level=0, full=0, overflow=0, underrun=0, irq=0, phase=left, pointers=0; FIFO RAM contents SHALL be unspecified.
REQ-027 SHALL abandon any half-written pair on reset or flush.

Configuration
REQ-028 SHALL support macro PCM_VOLUME_EN; when defined, 8-bit inputs vol_l and vol_r SHALL exist, and each popped sample SHALL be computed as (sample*vol)>>>8 (signed arithmetic); vol=8'hFF SHALL pass the sample unchanged, and output latency SHALL become 2 cycles after the tick.
REQ-029 SHALL, when PCM_VOLUME_EN is undefined, omit vol_l/vol_r and keep latency at 1 cycle.

Verification
REQ-030 SHALL test: writes 0x1234, 0x8000, then tick -> next cycle left_chan=0x12340000, right_chan=0x80000000, level 1->0.
REQ-031 SHALL test: 256 frames written, then a 257th pair -> full=1, overflow=1, level=256, frame 257 absent from pop order.
REQ-032 SHALL test: tick while empty -> outputs 0, underrun=1; udr_clr -> underrun=0.
REQ-033 SHALL test: IRQ_THRESH=128, irq_en=1, level 128->127 via tick -> irq rises one cycle later.
REQ-034 SHALL test: a single left write, then flush, then pair 0x0001/0x0002 -> popped frame left=0x0001, right=0x0002.
REQ-035 SHALL test (PCM_VOLUME_EN): sample 0x4000, vol 0x80 -> output top 16 bits 0x2000, two cycles after the tick.

Source files
------------

// File: rtl/pcm_frame_fifo.sv
// Stereo PCM frame FIFO between the ISA write port and the I2S serializer.
// Optional macro PCM_VOLUME_EN adds per-channel volume scaling (vol_l/vol_r) with one extra pipeline stage.
module pcm_frame_fifo #(
   parameter int AUDIO_DW   = 32,
   parameter int DEPTH_LOG2 = 8,
   parameter int IRQ_THRESH = 128
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wr_strobe,
   input  logic [15:0]           wr_data,
   input  logic                  flush,
   input  logic                  sample_tick,
   input  logic                  irq_en,
   input  logic                  ovf_clr,
   input  logic                  udr_clr,
`ifdef PCM_VOLUME_EN
   input  logic [7:0]            vol_l,
   input  logic [7:0]            vol_r,
`endif
   output logic [AUDIO_DW-1:0]   left_chan,
   output logic [AUDIO_DW-1:0]   right_chan,
   output logic [DEPTH_LOG2:0]   level,
   output logic                  full,
   output logic                  overflow,
   output logic                  underrun,
   output logic                  irq
);

   localparam int Depth = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] DepthLevel = (DEPTH_LOG2+1)'(Depth);
   localparam logic [DEPTH_LOG2:0] IrqLevel   = (DEPTH_LOG2+1)'(IRQ_THRESH);

   logic                  phase;
   logic [15:0]           stage_left;
   logic [DEPTH_LOG2-1:0] wr_ptr;
   logic [DEPTH_LOG2-1:0] rd_ptr;
   logic [DEPTH_LOG2:0]   level_q;
   logic [31:0]           mem [Depth];
   logic [31:0]           rd_frame;
   logic                  empty;
   logic                  commit;
   logic                  commit_ok;
   logic                  commit_drop;
   logic                  pop;
   logic                  starve;

   function automatic logic [AUDIO_DW-1:0] left_justify(input logic [15:0] s);
      left_justify = '0;
      left_justify[AUDIO_DW-1 -: 16] = s;
   endfunction

   assign level       = level_q;
   assign full        = (level_q == DepthLevel);
   assign empty       = (level_q == '0);
   assign commit      = wr_strobe & phase & ~flush;
   assign commit_ok   = commit & ~full;
   assign commit_drop = commit & full;
   // Emptiness is judged on the pre-commit level, so a same-cycle commit cannot rescue a tick.
   assign pop         = sample_tick & ~empty & ~flush;
   assign starve      = sample_tick & empty & ~flush;
   assign rd_frame    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (commit_ok)
         mem[wr_ptr] <= {stage_left, wr_data};
   end

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         phase      <= 1'b0;
         stage_left <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         level_q    <= '0;
      end else begin
         if (wr_strobe) begin
            phase <= ~phase;
            if (!phase)
               stage_left <= wr_data;
         end
         if (commit_ok)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({commit_ok, pop})
            2'b10:   level_q <= level_q + 1'b1;
            2'b01:   level_q <= level_q - 1'b1;
            default: level_q <= level_q;
         endcase
      end
   end

   // A set in the same cycle as its clear keeps the flag raised.
   always_ff @(posedge clk) begin
      if (reset) begin
         overflow <= 1'b0;
         underrun <= 1'b0;
         irq      <= 1'b0;
      end else begin
         overflow <= commit_drop | (overflow & ~ovf_clr);
         underrun <= starve | (underrun & ~udr_clr);
         irq      <= irq_en & (level_q < IrqLevel);
      end
   end

`ifdef PCM_VOLUME_EN
   logic        pipe_load;
   logic [15:0] pipe_l;
   logic [15:0] pipe_r;

   // vol is an unsigned gain in 1/256 steps; full scale is treated as unity.
   function automatic logic [15:0] scale(input logic [15:0] s, input logic [7:0] v);
      logic signed [24:0] prod;
      prod = $signed(s) * $signed({1'b0, v});
      scale = (v == 8'hFF) ? s : prod[23:8];
   endfunction

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         pipe_load  <= 1'b0;
         pipe_l     <= '0;
         pipe_r     <= '0;
         left_chan  <= '0;
         right_chan <= '0;
      end else begin
         pipe_load <= pop | starve;
         pipe_l    <= pop ? rd_frame[31:16] : 16'h0000;
         pipe_r    <= pop ? rd_frame[15:0]  : 16'h0000;
         if (pipe_load) begin
            left_chan  <= left_justify(scale(pipe_l, vol_l));
            right_chan <= left_justify(scale(pipe_r, vol_r));
         end
      end
   end
`else
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         left_chan  <= '0;
         right_chan <= '0;
      end else if (pop) begin
         left_chan  <= left_justify(rd_frame[31:16]);
         right_chan <= left_justify(rd_frame[15:0]);
      end else if (starve) begin
         left_chan  <= '0;
         right_chan <= '0;
      end
   end
`endif

endmodule

// File: tb/tb_pcm_frame_fifo.sv
// Self-checking bench for pcm_frame_fifo (default build): queue-based frame model plus directed checks.
module tb_pcm_frame_fifo;

   logic        clk = 1'b0;
   logic        reset;
   logic        wr_strobe;
   logic [15:0] wr_data;
   logic        flush;
   logic        sample_tick;
   logic        irq_en;
   logic        ovf_clr;
   logic        udr_clr;
   logic [31:0] left_chan;
   logic [31:0] right_chan;
   logic [8:0]  level;
   logic        full;
   logic        overflow;
   logic        underrun;
   logic        irq;

   int errors = 0;
   int checks = 0;

   pcm_frame_fifo #(.AUDIO_DW(32), .DEPTH_LOG2(8), .IRQ_THRESH(128)) dut (
      .clk(clk), .reset(reset), .wr_strobe(wr_strobe), .wr_data(wr_data),
      .flush(flush), .sample_tick(sample_tick), .irq_en(irq_en),
      .ovf_clr(ovf_clr), .udr_clr(udr_clr), .left_chan(left_chan),
      .right_chan(right_chan), .level(level), .full(full),
      .overflow(overflow), .underrun(underrun), .irq(irq)
   );

   always #5 clk = ~clk;

   // Reference model: a queue of committed frames and a half-pair holding slot.
   logic [31:0] q[$];
   logic        model_valid = 1'b0;
   logic        have_left;
   logic [15:0] left_hold;
   logic [31:0] exp_left, exp_right;
   logic        exp_ovf, exp_udr, exp_irq;

   always @(posedge clk) begin
      int sz;
      logic [31:0] f;
      logic ovf_set, udr_set;
      if (reset) begin
         q.delete();
         have_left = 1'b0; left_hold = '0;
         exp_left = '0; exp_right = '0;
         exp_ovf = 1'b0; exp_udr = 1'b0; exp_irq = 1'b0;
         model_valid = 1'b1;
      end else if (model_valid) begin
         sz = q.size();
         ovf_set = 1'b0;
         udr_set = 1'b0;
         exp_irq = irq_en && (sz < 128);
         if (flush) begin
            q.delete();
            have_left = 1'b0;
            exp_left = '0; exp_right = '0;
         end else begin
            if (sample_tick) begin
               if (sz > 0) begin
                  f = q.pop_front();
                  exp_left  = {f[31:16], 16'h0000};
                  exp_right = {f[15:0], 16'h0000};
               end else begin
                  exp_left = '0; exp_right = '0;
                  udr_set = 1'b1;
               end
            end
            if (wr_strobe) begin
               if (!have_left) begin
                  left_hold = wr_data;
                  have_left = 1'b1;
               end else begin
                  have_left = 1'b0;
                  if (sz == 256) ovf_set = 1'b1;
                  else q.push_back({left_hold, wr_data});
               end
            end
         end
         exp_ovf = ovf_set || (exp_ovf && !ovf_clr);
         exp_udr = udr_set || (exp_udr && !udr_clr);
      end
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (model_valid && !reset) begin
         checkOutput("model_left", left_chan, exp_left);
         checkOutput("model_right", right_chan, exp_right);
         checkOutput("model_level", level, q.size());
         checkOutput("model_full", full, q.size() == 256);
         checkOutput("model_overflow", overflow, exp_ovf);
         checkOutput("model_underrun", underrun, exp_udr);
         checkOutput("model_irq", irq, exp_irq);
      end
   end

   task automatic applyStimulus(input logic wr, input logic [15:0] d, input logic tk, input logic fl);
      wr_strobe = wr; wr_data = d; sample_tick = tk; flush = fl;
      @(posedge clk);
      @(negedge clk);
      wr_strobe = 1'b0; wr_data = '0; sample_tick = 1'b0; flush = 1'b0;
      ovf_clr = 1'b0; udr_clr = 1'b0;
   endtask

   initial begin
      reset = 1'b1; wr_strobe = 1'b0; wr_data = '0; flush = 1'b0;
      sample_tick = 1'b0; irq_en = 1'b0; ovf_clr = 1'b0; udr_clr = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("reset_left", left_chan, 32'h0);
      checkOutput("reset_level", level, 9'd0);
      checkOutput("reset_flags", {full, overflow, underrun, irq}, 4'b0000);
      reset = 1'b0;

      // Basic pair and pop
      applyStimulus(1'b1, 16'h1234, 1'b0, 1'b0);
      applyStimulus(1'b1, 16'h8000, 1'b0, 1'b0);
      checkOutput("pair_level", level, 9'd1);
      applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
      checkOutput("pop_left", left_chan, 32'h12340000);
      checkOutput("pop_right", right_chan, 32'h80000000);
      checkOutput("pop_level", level, 9'd0);

      // Underrun and its clear
      applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
      checkOutput("udr_left", left_chan, 32'h0);
      checkOutput("udr_flag", underrun, 1'b1);
      udr_clr = 1'b1;
      applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
      checkOutput("udr_clear", underrun, 1'b0);

      // Commit and tick together while empty
      applyStimulus(1'b1, 16'h1111, 1'b0, 1'b0);
      applyStimulus(1'b1, 16'h2222, 1'b1, 1'b0);
      checkOutput("same_cycle_level", level, 9'd1);
      checkOutput("same_cycle_udr", underrun, 1'b1);
      applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
      checkOutput("same_cycle_pop", left_chan, 32'h11110000);
      udr_clr = 1'b1;
      applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);

      // Half pair abandoned by flush
      applyStimulus(1'b1, 16'h7777, 1'b0, 1'b0);
      applyStimulus(1'b0, 16'h0, 1'b0, 1'b1);
      checkOutput("flush_outputs", left_chan, 32'h0);
      applyStimulus(1'b1, 16'h0001, 1'b0, 1'b0);
      applyStimulus(1'b1, 16'h0002, 1'b0, 1'b0);
      applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
      checkOutput("flush_left", left_chan, 32'h00010000);
      checkOutput("flush_right", right_chan, 32'h00020000);

      // Fill to capacity, then one extra pair
      for (int i = 0; i < 256; i++) begin
         applyStimulus(1'b1, 16'(i), 1'b0, 1'b0);
         applyStimulus(1'b1, 16'(i) | 16'h8000, 1'b0, 1'b0);
      end
      checkOutput("fill_full", full, 1'b1);
      checkOutput("fill_ovf_before", overflow, 1'b0);
      applyStimulus(1'b1, 16'hAAAA, 1'b0, 1'b0);
      applyStimulus(1'b1, 16'hBBBB, 1'b0, 1'b0);
      checkOutput("ovf_flag", overflow, 1'b1);
      checkOutput("ovf_level", level, 9'd256);
      irq_en = 1'b1;
      applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
      checkOutput("irq_full", irq, 1'b0);

      // Drain through the irq threshold
      for (int i = 0; i < 129; i++)
         applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
      checkOutput("thresh_level", level, 9'd127);
      checkOutput("thresh_irq_lag", irq, 1'b0);
      applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
      checkOutput("thresh_irq_rise", irq, 1'b1);
      for (int i = 0; i < 127; i++)
         applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
      checkOutput("last_left", left_chan, 32'h00FF0000);
      checkOutput("last_right", right_chan, 32'h80FF0000);
      applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
      checkOutput("no_frame_257", left_chan, 32'h0);
      checkOutput("no_frame_257_udr", underrun, 1'b1);

      // Randomized traffic in fill, drain and balanced segments
      for (int seg = 0; seg < 3; seg++) begin
         for (int n = 0; n < 1500; n++) begin
            int wr_pct, tk_pct;
            wr_pct = (seg == 0) ? 90 : (seg == 1) ? 20 : 55;
            tk_pct = (seg == 0) ? 20 : (seg == 1) ? 70 : 28;
            ovf_clr = ($urandom_range(0, 99) < 5);
            udr_clr = ($urandom_range(0, 99) < 5);
            if ($urandom_range(0, 99) < 3) irq_en = $urandom_range(0, 1);
            applyStimulus($urandom_range(0, 99) < wr_pct, 16'($urandom),
                          $urandom_range(0, 99) < tk_pct, $urandom_range(0, 999) < 4);
         end
      end

      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
